// File: rtl/uart_rx_if.sv
// Serial-side and byte-side signals of the 8N1 UART receiver.
// slave: the receiver itself; master: line driver plus downstream consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       rx_busy;

  modport master (
    output rx,
    input  rx_data,
    input  rx_ready,
    input  frame_error,
    input  rx_busy
  );

  modport slave (
    input  rx,
    output rx_data,
    output rx_ready,
    output frame_error,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, start-glitch rejection, stop-bit framing check.
// Emits one-cycle rx_ready / frame_error strobes toward the command-frame collector.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave uart
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDLE_ARM     = 10 * CLKS_PER_BIT;
  localparam int unsigned AW           = $clog2(IDLE_ARM + 1);

  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] C_ARM       = AW'(IDLE_ARM);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_sync_d;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_clk_cnt;
  logic [7:0]    r_shift_reg;
  logic [7:0]    r_rx_data;
  logic          r_rx_ready;
  logic          r_frame_error;
  logic [AW-1:0] r_idle_cnt;

  state_t        w_state_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [CW-1:0] w_clk_cnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_rx_data_nxt;
  logic          w_rx_ready_nxt;
  logic          w_frame_error_nxt;
  logic [AW-1:0] w_idle_cnt_nxt;
  logic          w_armed;
  logic          w_fall;

  // Two-flop synchroniser plus delayed copy for edge detection; all idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_sync_d <= 1'b1;
    end else begin
      r_rx_meta   <= uart.rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_sync_d <= r_rx_sync;
    end
  end

  // Frame starts are accepted only after a full character time of idle line
  // since reset, so a line held low or a frame cut by reset cannot start one.
  assign w_armed = (r_idle_cnt == C_ARM);
  assign w_fall  = !r_rx_sync && r_rx_sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_clk_cnt     <= '0;
      r_shift_reg   <= '0;
      r_rx_data     <= '0;
      r_rx_ready    <= 1'b0;
      r_frame_error <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_clk_cnt     <= w_clk_cnt_nxt;
      r_shift_reg   <= w_shift_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_ready    <= w_rx_ready_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_clk_cnt_nxt     = r_clk_cnt;
    w_shift_nxt       = r_shift_reg;
    w_rx_data_nxt     = r_rx_data;
    w_rx_ready_nxt    = 1'b0;
    w_frame_error_nxt = 1'b0;
    w_idle_cnt_nxt    = r_idle_cnt;

    unique case (r_state)
      IDLE: begin
        if (!w_armed) begin
          if (r_rx_sync) begin
            w_idle_cnt_nxt = r_idle_cnt + AW'(1);
          end else begin
            w_idle_cnt_nxt = '0;
          end
        end else if (w_fall) begin
          w_state_nxt   = START;
          w_clk_cnt_nxt = '0;
        end
      end

      START: begin
        if (r_clk_cnt == C_HALF_LAST) begin
          if (!r_rx_sync) begin
            w_state_nxt   = DATA;
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end

      DATA: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {r_rx_sync, r_shift_reg[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end

      STOP: begin
        // Leaving at the stop-bit centre lets an immediately following start edge be seen.
        if (r_clk_cnt == C_BIT_LAST) begin
          w_state_nxt = IDLE;
          if (r_rx_sync) begin
            w_rx_data_nxt  = r_shift_reg;
            w_rx_ready_nxt = 1'b1;
          end else begin
            w_frame_error_nxt = 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        end
      end
    endcase
  end

  assign uart.rx_data     = r_rx_data;
  assign uart.rx_ready    = r_rx_ready;
  assign uart.frame_error = r_frame_error;
  assign uart.rx_busy     = (r_state != IDLE);

endmodule
